// File: rtl/aes_pkg.sv
// Shared AES constants: lane width and the forward/inverse S-box tables.
package aes_pkg;

    localparam int unsigned LANE_W = 8;
    localparam int unsigned SBOX_N = 256;

    typedef logic [LANE_W-1:0] byte_t;

    localparam byte_t SBOX_FWD [SBOX_N] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam byte_t SBOX_INV [SBOX_N] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/sbox_lane.sv
// One byte lane: combinational forward or inverse AES S-box lookup.
module sbox_lane
    import aes_pkg::*;
(
    input  byte_t data_i,
    input  logic  inv_i,
    output byte_t data_o
);

    // Select the table by the mode bit that travels with the word.
    always_comb begin
        data_o = SBOX_FWD[data_i];
        if (inv_i) begin
            data_o = SBOX_INV[data_i];
        end
    end

endmodule

// File: rtl/sbox_array_pipe.sv
// LANES parallel S-box lanes behind a 1- or 2-stage valid/ready pipeline.
module sbox_array_pipe
    import aes_pkg::*;
#(
    parameter int unsigned LANES  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANE_W*LANES-1:0] in_data,
    input  logic                    in_inv,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANE_W*LANES-1:0] out_data,
    output logic                    out_inv
);

    localparam int unsigned W = LANE_W * LANES;

    logic         lut_valid;
    logic [W-1:0] lut_in;
    logic         lut_inv;
    logic [W-1:0] lut_out;

    logic         out_v_q, out_v_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic         out_inv_q, out_inv_d;
    logic         out_rdy;

    // Output stage can take a word when empty or when its word is leaving.
    assign out_rdy = !out_v_q || out_ready;

    if (STAGES == 2) begin : g_two
        logic         s0_v_q, s0_v_d;
        logic [W-1:0] s0_data_q, s0_data_d;
        logic         s0_inv_q, s0_inv_d;
        logic         s0_rdy;

        assign s0_rdy = !s0_v_q || out_rdy;

        // Stage 0 captures raw bytes and mode; data only moves with a valid word.
        always_comb begin
            s0_v_d    = s0_v_q;
            s0_data_d = s0_data_q;
            s0_inv_d  = s0_inv_q;
            if (s0_rdy) begin
                s0_v_d = in_valid;
                if (in_valid) begin
                    s0_data_d = in_data;
                    s0_inv_d  = in_inv;
                end
            end
        end

        // Stage 0 register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s0_v_q    <= 1'b0;
                s0_data_q <= '0;
                s0_inv_q  <= 1'b0;
            end else begin
                s0_v_q    <= s0_v_d;
                s0_data_q <= s0_data_d;
                s0_inv_q  <= s0_inv_d;
            end
        end

        assign in_ready  = s0_rdy;
        assign lut_valid = s0_v_q;
        assign lut_in    = s0_data_q;
        assign lut_inv   = s0_inv_q;
    end else begin : g_one
        assign in_ready  = out_rdy;
        assign lut_valid = in_valid;
        assign lut_in    = in_data;
        assign lut_inv   = in_inv;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sbox_lane u_lane (
            .data_i (lut_in[i*LANE_W +: LANE_W]),
            .inv_i  (lut_inv),
            .data_o (lut_out[i*LANE_W +: LANE_W])
        );
    end

    // Output stage loads the substituted word whenever it has room.
    always_comb begin
        out_v_d    = out_v_q;
        out_data_d = out_data_q;
        out_inv_d  = out_inv_q;
        if (out_rdy) begin
            out_v_d = lut_valid;
            if (lut_valid) begin
                out_data_d = lut_out;
                out_inv_d  = lut_inv;
            end
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_v_q    <= 1'b0;
            out_data_q <= '0;
            out_inv_q  <= 1'b0;
        end else begin
            out_v_q    <= out_v_d;
            out_data_q <= out_data_d;
            out_inv_q  <= out_inv_d;
        end
    end

    assign out_valid = out_v_q;
    assign out_data  = out_data_q;
    assign out_inv   = out_inv_q;

endmodule

// File: doc/sbox_array_pipe.md
SBOX_ARRAY_PIPE -- requirements
Module: sbox_array_pipe

Interface
REQ-001 The block SHALL have parameter LANES, default 4, giving the number of parallel byte lanes (legal 1..16).
REQ-002 The block SHALL have parameter STAGES, default 2, giving the pipeline depth (legal 1 or 2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream presents a word.
REQ-006 in_ready  output  1  block accepts the word this cycle.
REQ-007 in_data  input  8*LANES  input bytes; lane i = bits [8i+7:8i].
REQ-008 in_inv  input  1  0 = forward AES S-box, 1 = inverse S-box, per word.
REQ-009 out_valid  output  1  result word present.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_data  output  8*LANES  substituted bytes, lane-aligned with in_data.
REQ-012 out_inv  output  1  mode bit that travelled with the word.

Function
REQ-013 Each lane SHALL output FIPS-197 SubBytes(x) when the word's mode is 0 and InvSubBytes(x) when it is 1; lanes are independent.
REQ-014 A word SHALL be accepted when in_valid && in_ready; it is transferred out when out_valid && out_ready.
REQ-015 Each stage k SHALL hold a valid bit v[k], data and mode; ready[k] = !v[k] || ready[k+1], with ready[last+1] = out_ready, and in_ready = ready[0].
REQ-016 STAGES=1: lookup is combinational from in_data/in_inv into a single output register; latency 1 cycle.
REQ-017 STAGES=2: stage 0 registers raw bytes and mode, the lookup sits between stage 0 and stage 1, and stage 1 is the output register; latency 2 cycles.
REQ-018 With out_ready held 1, throughput SHALL be one word per cycle, with no bubbles.
REQ-019 While out_valid && !out_ready, out_data, out_inv and out_valid SHALL hold stable.
REQ-020 When all stages are full and out_ready=1, the block SHALL accept a new word in the same cycle the oldest word leaves.
REQ-021 Words SHALL exit in acceptance order; mixed forward/inverse words back-to-back need no drain or bubble.
REQ-022 in_valid is not required to stay asserted; a word not accepted is simply not captured.
REQ-023 Input or output X on lanes of an invalid stage SHALL NOT propagate to out_valid or in_ready.
REQ-024 No combinational path SHALL exist from in_valid or in_data to out_*; out_ready-to-in_ready is the only combinational path.

Reset
REQ-025 On rst_n low, all v[k], out_valid, out_data and out_inv SHALL clear to 0 immediately, regardless of clk.
REQ-026 Reset mid-operation SHALL discard all in-flight words; after release the first accepted word appears after exactly STAGES cycles.
REQ-027 in_ready SHALL be 1 one cycle after reset release, and also combinationally while rst_n is low.

Structure
REQ-028 The forward and inverse 256-entry S-box tables SHALL live as constants in shared package aes_pkg, alongside LANE_W=8.
REQ-029 One sub-module sbox_lane (8-bit in, mode in, 8-bit out, combinational, both tables) SHALL be instantiated LANES times by generate.
REQ-030 Pipeline registers and the handshake SHALL reside only in sbox_array_pipe; target size is 120-400 RTL lines.

Verification
REQ-031 LANES=4, STAGES=2, in_data=0x5301FF00, in_inv=0 -> two cycles later out_data=0xED7C1663, out_inv=0.
REQ-032 in_data=0xED7C1663, in_inv=1 -> out_data=0x5301FF00, out_inv=1; alternating forward/inverse words every cycle -> correct result each cycle, no bubbles.
REQ-033 Exhaustive sweep of all 256 bytes in every lane, both modes -> matches the golden FIPS-197 tables, and inverse(forward(x))=x.
REQ-034 out_ready held 0 for 5 cycles with a continuous in_valid stream -> in_ready falls after STAGES words; out_data stays stable; after release, order is preserved with no loss or duplication.
REQ-035 rst_n asserted while 2 words are in flight -> out_valid drops to 0 asynchronously; after release with in_data=0x00000000, in_inv=0 -> out_data=0x63636363 after STAGES cycles.
REQ-036 Repeat REQ-031 and REQ-034 with STAGES=1, LANES=1 -> latency 1 cycle and identical data.
